dsi_hs_rx_aligner: RTL and testbench
====================================

Name: dsi_hs_rx_aligner

Overview:
- Receive-side counterpart of the lane serializer: consumes 8-bit parallel words from a per-lane 1:8 deserializer in the logic clock domain.
- Hunts for the D-PHY HS sync sequence (00011101 on the wire, byte value 8'hB8, LSB first) at any of 8 bit offsets, then locks that offset.
- After lock, emits byte-aligned payload with SoT/EoT framing until the lane leaves HS mode.
- Used for loopback verification of the DSI transmit path and as the data-lane front end for bus-turnaround read-back.

Parameters:
- SYNC_BYTE, 8'hB8, aligned value of the HS sync sequence (LSB = first bit on wire).
- HUNT_TIMEOUT, 16, maximum rx_clock_logic cycles spent in HUNT before declaring an SoT error; legal range 2..255.

Ports:
- rx_clock_logic  in  1  logic-domain clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- rx_hs_en  in  1  lane is in HS receive mode (from LP state detector); level.
- rx_in  in  8  deserialized word; rx_in[0] = earliest received bit.
- rx_data  out  8  aligned byte.
- rx_valid  out  1  rx_data valid this cycle.
- rx_sot  out  1  one-cycle pulse coincident with the first valid byte after sync.
- rx_eot  out  1  one-cycle pulse when HS ends while locked.
- rx_sot_err  out  1  one-cycle pulse on hunt timeout.
- rx_active  out  1  high while in SYNCED.
- rx_offset  out  3  locked bit offset; holds its value after the burst ends.

Behaviour:
- Reset: all outputs 0, prev_q = 8'h00, state = IDLE, timer = 0. Reset is checked every clock, so it aborts any burst with no rx_eot.
- prev_q <= rx_in every cycle. Window w = {rx_in, prev_q} (16 bits). Candidate k = w[k+7:k] for k = 0..7.
- States:
  - IDLE: on rx_hs_en = 1, go to HUNT with timer = 0. Sync search is also performed in this same cycle.
  - HUNT:
    - If any candidate equals SYNC_BYTE, lock the lowest matching k into rx_offset and go to SYNCED.
    - Otherwise timer++. When timer reaches HUNT_TIMEOUT-1 with no match, pulse rx_sot_err and go to WAIT_EOT.
  - SYNCED: every cycle, rx_data <= w[off+7:off] and rx_valid <= 1. The first such byte also sets rx_sot.
  - WAIT_EOT: outputs idle; go to IDLE when rx_hs_en = 0.
- Latency: the match is evaluated in cycle n. The first payload byte is evaluated from the window in cycle n+1 and registered on that edge, so rx_valid/rx_sot are visible in cycle n+2. Steady state thereafter is one byte per clock.
- rx_hs_en = 0 in SYNCED:
  - The window in that cycle is not emitted.
  - rx_valid <= 0, rx_eot <= 1 for one cycle, rx_active <= 0, go to IDLE.
  - HS trailer bits are not stripped; the protocol layer discards them.
- rx_hs_en = 0 in HUNT: go to IDLE silently (no eot, no err).
- Simultaneous events:
  - rx_hs_en = 0 plus a sync match in the same cycle: rx_hs_en wins, go to IDLE.
  - Timeout plus a match in the same cycle: the match wins.
- Lock is never re-evaluated inside SYNCED; a later 8'hB8 in the payload is ordinary data.
- rx_data holds its last value when rx_valid = 0.

Decomposition:
- Package dsi_rx_pkg:
  - SYNC_BYTE_DEFAULT = 8'hB8.
  - State encoding: IDLE, HUNT, SYNCED, WAIT_EOT (2-bit enum).
  - Offset width constant = 3.
- One natural combinational sub-module, dsi_rx_sync_search:
  - input w[15:0]; outputs hit and k[2:0].
  - Priority-encodes the lowest matching offset.
  - Reusable per lane.

Test Plan:
- Offset 0: rst, then rx_hs_en = 1 with rx_in = 00, B8, 55, AA. Match at offset 0 in the 55 cycle → rx_valid two cycles later with 55 (rx_sot = 1), then AA. rx_offset = 0.
- Offset 3: rx_in = 00, C0, AD, 0A (55 and 41 shifted by 3) → match at the AD cycle, rx_offset = 3, first bytes 55 then 41, rx_sot on 55.
- Timeout: rx_hs_en = 1 with rx_in = 00 forever, HUNT_TIMEOUT = 16 → rx_sot_err pulses once in cycle 16 of HS, no rx_valid. Dropping rx_hs_en returns to IDLE; a fresh burst then locks normally.
- EoT: locked burst of 4 bytes, then rx_hs_en = 0 → rx_valid drops the same edge, single rx_eot pulse, rx_active = 0, no extra byte emitted.
- Payload B8: after lock at offset 5, a payload containing B8 → output as data, rx_offset stays 5, no second rx_sot.
- Reset mid-burst: rst = 1 while SYNCED → next edge all outputs 0, no rx_eot. A new burst with rx_hs_en still high after rst deasserts relocks.

Source files
------------

// File: rtl/dsi_rx_pkg.sv
// Shared constants and state encoding for the D-PHY HS receive aligner.
package dsi_rx_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hB8;
  localparam int unsigned OFFSET_W          = 3;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    SYNCED,
    WAIT_EOT
  } rx_state_e;

endpackage

// File: rtl/dsi_rx_sync_search.sv
// Finds the HS sync byte at any of the 8 bit offsets of a 16-bit window and
// reports the lowest matching offset.
module dsi_rx_sync_search
  import dsi_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic [15:0]         w,
  output logic                hit,
  output logic [OFFSET_W-1:0] k
);

  logic [7:0] match;
  logic       unused_w15;

  // The top window bit never starts or ends a candidate byte.
  assign unused_w15 = w[15];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_cand
      assign match[gi] = (w[gi +: 8] == SYNC_BYTE);
    end
  endgenerate

  assign hit = |match;

  always_comb begin
    k = '0;
    for (int i = 7; i >= 0; i--) begin
      if (match[i]) begin
        k = OFFSET_W'(i);
      end
    end
  end

endmodule

// File: rtl/dsi_hs_rx_aligner.sv
// HS lane receive aligner: hunts for the sync byte across all bit offsets of the
// deserialized stream, locks the offset, and emits framed byte-aligned payload.
module dsi_hs_rx_aligner
  import dsi_rx_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int unsigned HUNT_TIMEOUT = 16
) (
  input  logic                rx_clock_logic,
  input  logic                rst,
  input  logic                rx_hs_en,
  input  logic [7:0]          rx_in,
  output logic [7:0]          rx_data,
  output logic                rx_valid,
  output logic                rx_sot,
  output logic                rx_eot,
  output logic                rx_sot_err,
  output logic                rx_active,
  output logic [OFFSET_W-1:0] rx_offset
);

  localparam logic [7:0] TIMER_LAST = 8'(HUNT_TIMEOUT - 1);

  rx_state_e           state_q;
  logic [7:0]          prev_q;
  logic [7:0]          timer_q;
  logic [7:0]          data_q;
  logic                valid_q;
  logic                sot_q;
  logic                eot_q;
  logic                err_q;
  logic [OFFSET_W-1:0] offset_q;

  logic [15:0]         window;
  logic                hit;
  logic [OFFSET_W-1:0] hit_k;
  logic [7:0]          timer_d;
  logic                timeout;

  assign window  = {rx_in, prev_q};
  assign timer_d = timer_q + 8'd1;
  assign timeout = (timer_d == TIMER_LAST);

  dsi_rx_sync_search #(
    .SYNC_BYTE (SYNC_BYTE)
  ) u_search (
    .w   (window),
    .hit (hit),
    .k   (hit_k)
  );

  always_ff @(posedge rx_clock_logic) begin
    if (rst) begin
      state_q  <= IDLE;
      prev_q   <= 8'h00;
      timer_q  <= 8'h00;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      sot_q    <= 1'b0;
      eot_q    <= 1'b0;
      err_q    <= 1'b0;
      offset_q <= '0;
    end else begin
      prev_q  <= rx_in;
      valid_q <= 1'b0;
      sot_q   <= 1'b0;
      eot_q   <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rx_hs_en) begin
            timer_q <= 8'h00;
            if (hit) begin
              offset_q <= hit_k;
              state_q  <= SYNCED;
            end else begin
              state_q <= HUNT;
            end
          end
        end
        HUNT: begin
          // Dropping HS beats a match, and a match beats the timeout.
          if (!rx_hs_en) begin
            state_q <= IDLE;
          end else if (hit) begin
            offset_q <= hit_k;
            state_q  <= SYNCED;
          end else if (timeout) begin
            err_q   <= 1'b1;
            state_q <= WAIT_EOT;
          end else begin
            timer_q <= timer_d;
          end
        end
        SYNCED: begin
          if (!rx_hs_en) begin
            eot_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            data_q  <= window[offset_q +: 8];
            valid_q <= 1'b1;
            // valid_q is low only during the first cycle after lock.
            sot_q   <= !valid_q;
          end
        end
        WAIT_EOT: begin
          if (!rx_hs_en) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign rx_sot     = sot_q;
  assign rx_eot     = eot_q;
  assign rx_sot_err = err_q;
  assign rx_active  = (state_q == SYNCED);
  assign rx_offset  = offset_q;

endmodule

// File: tb/tb_dsi_hs_rx_aligner.sv
// Directed testbench for dsi_hs_rx_aligner: each step drives one word, then
// compares {valid,sot,eot,sot_err,active,data,offset} against a hand-derived value.
module tb_dsi_hs_rx_aligner;

  localparam logic [4:0] S_I   = 5'b00000;
  localparam logic [4:0] S_L   = 5'b00001;
  localparam logic [4:0] S_SOT = 5'b11001;
  localparam logic [4:0] S_D   = 5'b10001;
  localparam logic [4:0] S_E   = 5'b00100;
  localparam logic [4:0] S_ERR = 5'b00010;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       hs_en = 1'b0;
  logic [7:0] din   = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_sot;
  logic       rx_eot;
  logic       rx_sot_err;
  logic       rx_active;
  logic [2:0] rx_offset;
  logic [15:0] obs;

  int n_vec  = 0;
  int n_miss = 0;

  dsi_hs_rx_aligner #(
    .SYNC_BYTE    (8'hB8),
    .HUNT_TIMEOUT (16)
  ) dut (
    .rx_clock_logic (clk),
    .rst            (rst),
    .rx_hs_en       (hs_en),
    .rx_in          (din),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_sot         (rx_sot),
    .rx_eot         (rx_eot),
    .rx_sot_err     (rx_sot_err),
    .rx_active      (rx_active),
    .rx_offset      (rx_offset)
  );

  always #5 clk = ~clk;

  assign obs = {rx_valid, rx_sot, rx_eot, rx_sot_err, rx_active, rx_data, rx_offset};

  task automatic apply(input logic [7:0] d, input logic en);
    din   = d;
    hs_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply(8'hFF, 1'b1);
      n_vec++;
      if (obs !== 16'h0000) begin
        n_miss++;
        $display("FAIL reset[%0d]: got st=%b data=%h off=%0d, want all zero",
                 i, obs[15:11], obs[10:3], obs[2:0]);
      end
    end
    rst = 1'b0;
    apply(8'h00, 1'b0);
    n_vec++;
    if (obs !== 16'h0000) begin
      n_miss++;
      $display("FAIL reset_release: got st=%b data=%h off=%0d, want all zero",
               obs[15:11], obs[10:3], obs[2:0]);
    end
  endtask

  task automatic test_offset0();
    logic [7:0]  di [8];
    logic        en [8];
    logic [15:0] ex [8];
    di = '{8'h00, 8'h00, 8'hB8, 8'h55, 8'hAA, 8'h00, 8'h00, 8'h00};
    en = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    ex = '{{S_I, 8'h00, 3'd0}, {S_I, 8'h00, 3'd0}, {S_I, 8'h00, 3'd0}, {S_L, 8'h00, 3'd0},
           {S_SOT, 8'h55, 3'd0}, {S_D, 8'hAA, 3'd0}, {S_E, 8'hAA, 3'd0}, {S_I, 8'hAA, 3'd0}};
    for (int i = 0; i < 8; i++) begin
      apply(di[i], en[i]);
      n_vec++;
      if (obs !== ex[i]) begin
        n_miss++;
        $display("FAIL offset0[%0d]: got st=%b data=%h off=%0d, want st=%b data=%h off=%0d",
                 i, obs[15:11], obs[10:3], obs[2:0], ex[i][15:11], ex[i][10:3], ex[i][2:0]);
      end
    end
  endtask

  task automatic test_offset3();
    logic [7:0]  di [7];
    logic        en [7];
    logic [15:0] ex [7];
    di = '{8'h00, 8'hC0, 8'hAD, 8'h0A, 8'h02, 8'h00, 8'h00};
    en = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    ex = '{{S_I, 8'hAA, 3'd0}, {S_I, 8'hAA, 3'd0}, {S_L, 8'hAA, 3'd3}, {S_SOT, 8'h55, 3'd3},
           {S_D, 8'h41, 3'd3}, {S_E, 8'h41, 3'd3}, {S_I, 8'h41, 3'd3}};
    for (int i = 0; i < 7; i++) begin
      apply(di[i], en[i]);
      n_vec++;
      if (obs !== ex[i]) begin
        n_miss++;
        $display("FAIL offset3[%0d]: got st=%b data=%h off=%0d, want st=%b data=%h off=%0d",
                 i, obs[15:11], obs[10:3], obs[2:0], ex[i][15:11], ex[i][10:3], ex[i][2:0]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [7:0]  di [8];
    logic        en [8];
    logic [15:0] ex [8];
    logic [15:0] want;
    for (int i = 0; i < 16; i++) begin
      apply(8'h00, 1'b1);
      want = (i == 15) ? {S_ERR, 8'h41, 3'd3} : {S_I, 8'h41, 3'd3};
      n_vec++;
      if (obs !== want) begin
        n_miss++;
        $display("FAIL timeout_hunt[%0d]: got st=%b data=%h off=%0d, want st=%b data=%h off=%0d",
                 i, obs[15:11], obs[10:3], obs[2:0], want[15:11], want[10:3], want[2:0]);
      end
    end
    di = '{8'h00, 8'h00, 8'h00, 8'hB8, 8'h55, 8'hAA, 8'h00, 8'h00};
    en = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    ex = '{{S_I, 8'h41, 3'd3}, {S_I, 8'h41, 3'd3}, {S_I, 8'h41, 3'd3}, {S_I, 8'h41, 3'd3},
           {S_L, 8'h41, 3'd0}, {S_SOT, 8'h55, 3'd0}, {S_E, 8'h55, 3'd0}, {S_I, 8'h55, 3'd0}};
    for (int i = 0; i < 8; i++) begin
      apply(di[i], en[i]);
      n_vec++;
      if (obs !== ex[i]) begin
        n_miss++;
        $display("FAIL timeout_recover[%0d]: got st=%b data=%h off=%0d, want st=%b data=%h off=%0d",
                 i, obs[15:11], obs[10:3], obs[2:0], ex[i][15:11], ex[i][10:3], ex[i][2:0]);
      end
    end
  endtask

  task automatic test_timeout_vs_match();
    logic [7:0]  di [5];
    logic        en [5];
    logic [15:0] ex [5];
    for (int i = 0; i < 14; i++) begin
      apply(8'h00, 1'b1);
      n_vec++;
      if (obs !== {S_I, 8'h55, 3'd0}) begin
        n_miss++;
        $display("FAIL tvm_hunt[%0d]: got st=%b data=%h off=%0d, want st=%b data=55 off=0",
                 i, obs[15:11], obs[10:3], obs[2:0], S_I);
      end
    end
    di = '{8'hB8, 8'h66, 8'h77, 8'h00, 8'h00};
    en = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    ex = '{{S_I, 8'h55, 3'd0}, {S_L, 8'h55, 3'd0}, {S_SOT, 8'h66, 3'd0},
           {S_E, 8'h66, 3'd0}, {S_I, 8'h66, 3'd0}};
    for (int i = 0; i < 5; i++) begin
      apply(di[i], en[i]);
      n_vec++;
      if (obs !== ex[i]) begin
        n_miss++;
        $display("FAIL tvm[%0d]: got st=%b data=%h off=%0d, want st=%b data=%h off=%0d",
                 i, obs[15:11], obs[10:3], obs[2:0], ex[i][15:11], ex[i][10:3], ex[i][2:0]);
      end
    end
  endtask

  task automatic test_eot();
    logic [7:0]  di [10];
    logic        en [10];
    logic [15:0] ex [10];
    di = '{8'h00, 8'hB8, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h00};
    en = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ex = '{{S_I, 8'h66, 3'd0}, {S_I, 8'h66, 3'd0}, {S_L, 8'h66, 3'd0}, {S_SOT, 8'h11, 3'd0},
           {S_D, 8'h22, 3'd0}, {S_D, 8'h33, 3'd0}, {S_D, 8'h44, 3'd0}, {S_E, 8'h44, 3'd0},
           {S_I, 8'h44, 3'd0}, {S_I, 8'h44, 3'd0}};
    for (int i = 0; i < 10; i++) begin
      apply(di[i], en[i]);
      n_vec++;
      if (obs !== ex[i]) begin
        n_miss++;
        $display("FAIL eot[%0d]: got st=%b data=%h off=%0d, want st=%b data=%h off=%0d",
                 i, obs[15:11], obs[10:3], obs[2:0], ex[i][15:11], ex[i][10:3], ex[i][2:0]);
      end
    end
  endtask

  task automatic test_payload_b8();
    logic [7:0]  di [8];
    logic        en [8];
    logic [15:0] ex [8];
    di = '{8'h00, 8'h57, 8'h02, 8'h97, 8'h06, 8'h00, 8'h00, 8'h00};
    en = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    ex = '{{S_I, 8'h44, 3'd0}, {S_L, 8'h44, 3'd5}, {S_SOT, 8'h12, 3'd5}, {S_D, 8'hB8, 3'd5},
           {S_D, 8'h34, 3'd5}, {S_D, 8'h00, 3'd5}, {S_E, 8'h00, 3'd5}, {S_I, 8'h00, 3'd5}};
    for (int i = 0; i < 8; i++) begin
      apply(di[i], en[i]);
      n_vec++;
      if (obs !== ex[i]) begin
        n_miss++;
        $display("FAIL payload_b8[%0d]: got st=%b data=%h off=%0d, want st=%b data=%h off=%0d",
                 i, obs[15:11], obs[10:3], obs[2:0], ex[i][15:11], ex[i][10:3], ex[i][2:0]);
      end
    end
  endtask

  task automatic test_hs_drop_vs_match();
    logic [7:0]  di [5];
    logic        en [5];
    di = '{8'h00, 8'hB8, 8'h55, 8'hAA, 8'h00};
    en = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      apply(di[i], en[i]);
      n_vec++;
      if (obs !== {S_I, 8'h00, 3'd5}) begin
        n_miss++;
        $display("FAIL drop_vs_match[%0d]: got st=%b data=%h off=%0d, want st=%b data=00 off=5",
                 i, obs[15:11], obs[10:3], obs[2:0], S_I);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0]  di [10];
    logic        en [10];
    logic        rs [10];
    logic [15:0] ex [10];
    di = '{8'h00, 8'hC0, 8'hAD, 8'h0A, 8'h02, 8'h00, 8'hB8, 8'h55, 8'hAA, 8'h00};
    en = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    rs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ex = '{{S_I, 8'h00, 3'd5}, {S_I, 8'h00, 3'd5}, {S_L, 8'h00, 3'd3}, {S_SOT, 8'h55, 3'd3},
           {S_I, 8'h00, 3'd0}, {S_I, 8'h00, 3'd0}, {S_I, 8'h00, 3'd0}, {S_L, 8'h00, 3'd0},
           {S_SOT, 8'h55, 3'd0}, {S_E, 8'h55, 3'd0}};
    for (int i = 0; i < 10; i++) begin
      rst = rs[i];
      apply(di[i], en[i]);
      n_vec++;
      if (obs !== ex[i]) begin
        n_miss++;
        $display("FAIL reset_mid[%0d]: got st=%b data=%h off=%0d, want st=%b data=%h off=%0d",
                 i, obs[15:11], obs[10:3], obs[2:0], ex[i][15:11], ex[i][10:3], ex[i][2:0]);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_offset0();
    test_offset3();
    test_timeout();
    test_timeout_vs_match();
    test_eot();
    test_payload_b8();
    test_hs_drop_vs_match();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
